// File: rtl/y86_pkg.sv
// y86_pkg: Y86 icode/ifun constants, condition-code struct and execute FSM states.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] ALUADD = 4'h0;
    localparam logic [3:0] ALUSUB = 4'h1;
    localparam logic [3:0] ALUAND = 4'h2;
    localparam logic [3:0] ALUXOR = 4'h3;
    localparam logic [3:0] ALUMUL = 4'h4;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    typedef enum logic {IDLE, MUL} exe_state_t;

endpackage

// File: rtl/y86_cond_eval.sv
// y86_cond_eval: evaluates a Y86 condition ifun against the CC flags; flags unknown ifun codes.
module y86_cond_eval
    import y86_pkg::*;
(
    input  cc_t        i_cc,
    input  logic [3:0] i_ifun,
    output logic       o_cnd,
    output logic       o_bad_ifun
);

    logic w_lt;

    assign w_lt = i_cc.sf ^ i_cc.of;

    always_comb begin
        o_cnd      = 1'b0;
        o_bad_ifun = 1'b0;
        case (i_ifun)
            C_YES:   o_cnd = 1'b1;
            C_LE:    o_cnd = w_lt | i_cc.zf;
            C_L:     o_cnd = w_lt;
            C_E:     o_cnd = i_cc.zf;
            C_NE:    o_cnd = !i_cc.zf;
            C_GE:    o_cnd = !w_lt;
            C_G:     o_cnd = !w_lt && !i_cc.zf;
            default: o_bad_ifun = 1'b1;
        endcase
    end

endmodule

// File: rtl/y86_execute_stage.sv
// y86_execute_stage: registered Y86 execute stage with CC register and valid/ready handshakes.
// Define Y86_MUL_EN to add an iterative shift-add mulq (OPq ifun 4).
module y86_execute_stage
    import y86_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int STK_STEP = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valB,
    input  logic [DATA_W-1:0] valC,
    input  logic              set_cc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] valE,
    output logic              cnd,
    output logic              exe_err,
    output logic              cc_zf,
    output logic              cc_sf,
    output logic              cc_of
);

    logic              r_out_valid, r_cnd, r_err;
    logic [DATA_W-1:0] r_vale;
    cc_t               r_cc;

    logic              w_acc, w_idle, w_is_mul, w_mul_done, w_mul_setcc;
    logic              w_cnd, w_err, w_cc_we, w_ce_cnd, w_bad_cond;
    logic              w_alu_bad, w_alu_of, w_sa, w_sb, w_sr;
    logic [DATA_W-1:0] w_alu, w_vale, w_prod_nx;
    cc_t               w_cc_new;

    y86_cond_eval u_cond (
        .i_cc       (r_cc),
        .i_ifun     (ifun),
        .o_cnd      (w_ce_cnd),
        .o_bad_ifun (w_bad_cond)
    );

    assign in_ready  = w_idle && (!r_out_valid || out_ready);
    assign w_acc     = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign valE      = r_vale;
    assign cnd       = r_cnd;
    assign exe_err   = r_err;
    assign cc_zf     = r_cc.zf;
    assign cc_sf     = r_cc.sf;
    assign cc_of     = r_cc.of;

    always_comb begin
        w_alu     = '0;
        w_alu_bad = 1'b0;
        case (ifun)
            ALUADD:  w_alu = valB + valA;
            ALUSUB:  w_alu = valB - valA;
            ALUAND:  w_alu = valB & valA;
            ALUXOR:  w_alu = valB ^ valA;
            default: w_alu_bad = 1'b1;
        endcase
    end

    assign w_sa     = valA[DATA_W-1];
    assign w_sb     = valB[DATA_W-1];
    assign w_sr     = w_alu[DATA_W-1];
    assign w_alu_of = (ifun == ALUADD) ? (w_sa == w_sb && w_sr != w_sb) :
                      (ifun == ALUSUB) ? (w_sa != w_sb && w_sr != w_sb) : 1'b0;
    assign w_cc_new = '{zf: (w_alu == '0), sf: w_sr, of: w_alu_of};

    always_comb begin
        w_vale  = '0;
        w_cnd   = 1'b0;
        w_err   = 1'b0;
        w_cc_we = 1'b0;
        case (icode)
            IIRMOVQ:          w_vale = valC;
            IRMMOVQ, IMRMOVQ: w_vale = valB + valC;
            ICALL, IPUSHQ:    w_vale = valB - DATA_W'(STK_STEP);
            IRET, IPOPQ:      w_vale = valB + DATA_W'(STK_STEP);
            IRRMOVQ: begin
                w_vale = valA;
                w_cnd  = w_ce_cnd;
                w_err  = w_bad_cond;
            end
            IJXX: begin
                w_cnd = w_ce_cnd;
                w_err = w_bad_cond;
            end
            IOPQ: begin
                w_vale  = w_alu;
                w_err   = w_alu_bad && !w_is_mul;
                w_cc_we = set_cc && !w_alu_bad;
            end
            default: ;
        endcase
    end

`ifdef Y86_MUL_EN
    localparam int CW = $clog2(DATA_W);

    exe_state_t        r_state, w_state_nx;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_mcand, r_mplier, r_prod;
    logic              r_mul_setcc;

    assign w_is_mul    = (icode == IOPQ) && (ifun == ALUMUL);
    assign w_idle      = (r_state == IDLE);
    assign w_mul_done  = (r_state == MUL) && (r_cnt == CW'(DATA_W - 1));
    assign w_prod_nx   = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_setcc = r_mul_setcc;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_acc && w_is_mul) w_state_nx = MUL;
            MUL:     if (w_mul_done) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Low DATA_W bits of the unsigned shift-add product equal the two's-complement product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_prod      <= '0;
            r_mul_setcc <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_acc) begin
                r_cnt       <= '0;
                r_mcand     <= valB;
                r_mplier    <= valA;
                r_prod      <= '0;
                r_mul_setcc <= set_cc;
            end else if (r_state == MUL) begin
                r_cnt    <= r_cnt + 1'b1;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_prod   <= w_prod_nx;
            end
        end
    end
`else
    assign w_is_mul    = 1'b0;
    assign w_idle      = 1'b1;
    assign w_mul_done  = 1'b0;
    assign w_prod_nx   = '0;
    assign w_mul_setcc = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_vale      <= '0;
            r_cnd       <= 1'b0;
            r_err       <= 1'b0;
            r_cc        <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
        end else if (w_acc && !w_is_mul) begin
            r_out_valid <= 1'b1;
            r_vale      <= w_vale;
            r_cnd       <= w_cnd;
            r_err       <= w_err;
            if (w_cc_we) r_cc <= w_cc_new;
        end else if (w_acc) begin
            r_out_valid <= 1'b0;
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_vale      <= w_prod_nx;
            r_cnd       <= 1'b0;
            r_err       <= 1'b0;
            if (w_mul_setcc) r_cc <= '{zf: (w_prod_nx == '0), sf: w_prod_nx[DATA_W-1], of: 1'b0};
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_y86_execute_stage.sv
// tb_y86_execute_stage: random + directed stimulus, reference model feeding a scoreboard
// that a free-running monitor drains whenever the stage hands a result to the memory side.
module tb_y86_execute_stage;

    localparam int DATA_W   = 64;
    localparam int STK_STEP = 8;

    typedef logic [DATA_W-1:0] word_t;
    typedef struct {
        word_t vale;
        logic  cnd;
        logic  err;
        logic  zf;
        logic  sf;
        logic  of;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, set_cc = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid, cnd, exe_err, cc_zf, cc_sf, cc_of;
    logic [3:0] icode = '0, ifun = '0;
    word_t      valA = '0, valB = '0, valC = '0, valE;

    int   errors = 0, checks = 0, rdy_mode = 0;
    exp_t sb[$];
    logic m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;

    y86_execute_stage #(.DATA_W(DATA_W), .STK_STEP(STK_STEP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC), .set_cc(set_cc),
        .out_valid(out_valid), .out_ready(out_ready), .valE(valE), .cnd(cnd), .exe_err(exe_err),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_zf = 1'b1;
        m_sf = 1'b0;
        m_of = 1'b0;
    endtask

    // Overflow is judged by whether the exact (DATA_W+1)-bit signed result fits in DATA_W bits.
    function automatic exp_t model(input logic [3:0] ic, input logic [3:0] fn,
                                   input word_t a, input word_t b, input word_t c, input logic sc);
        exp_t e;
        logic signed [DATA_W:0] wide;
        logic ok, lt, of;
        e  = '{vale: '0, cnd: 1'b0, err: 1'b0, zf: 1'b0, sf: 1'b0, of: 1'b0};
        lt = m_sf ^ m_of;
        of = 1'b0;
        ok = 1'b1;
        case (ic)
            4'h2, 4'h7: begin
                case (fn)
                    4'd0:    e.cnd = 1'b1;
                    4'd1:    e.cnd = lt | m_zf;
                    4'd2:    e.cnd = lt;
                    4'd3:    e.cnd = m_zf;
                    4'd4:    e.cnd = !m_zf;
                    4'd5:    e.cnd = !lt;
                    4'd6:    e.cnd = !lt && !m_zf;
                    default: e.err = 1'b1;
                endcase
                if (ic == 4'h2) e.vale = a;
            end
            4'h3:       e.vale = c;
            4'h4, 4'h5: e.vale = b + c;
            4'h8, 4'hA: e.vale = b - word_t'(STK_STEP);
            4'h9, 4'hB: e.vale = b + word_t'(STK_STEP);
            4'h6: begin
                case (fn)
                    4'd0: begin
                        e.vale = b + a;
                        wide   = $signed(b) + $signed(a);
                        of     = (wide != $signed(e.vale));
                    end
                    4'd1: begin
                        e.vale = b - a;
                        wide   = $signed(b) - $signed(a);
                        of     = (wide != $signed(e.vale));
                    end
                    4'd2: e.vale = b & a;
                    4'd3: e.vale = b ^ a;
`ifdef Y86_MUL_EN
                    4'd4: e.vale = b * a;
`endif
                    default: begin
                        ok    = 1'b0;
                        e.err = 1'b1;
                    end
                endcase
                if (ok && sc) begin
                    m_zf = (e.vale == '0);
                    m_sf = e.vale[DATA_W-1];
                    m_of = of;
                end
            end
            default: ;
        endcase
        e.zf = m_zf;
        e.sf = m_sf;
        e.of = m_of;
        return e;
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                         input word_t a, input word_t b, input word_t c, input logic sc);
        int n = 0;
        icode = ic; ifun = fn; valA = a; valB = b; valC = c; set_cc = sc; in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %b expected 1", in_ready);
        end else begin
            sb.push_back(model(ic, fn, a, b, c, sc));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending %0d expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = (rdy_mode == 0) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    end

    initial begin
        exp_t  e;
        word_t held_v;
        logic  held;
        held = 1'b0;
        held_v = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    checkb("hold_valid", out_valid, 1'b1);
                    check("hold_valE", valE, held_v);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got valE %h expected no output", valE);
                    end else begin
                        e = sb.pop_front();
                        check("valE", valE, e.vale);
                        checkb("cnd", cnd, e.cnd);
                        checkb("exe_err", exe_err, e.err);
                        checkb("cc_zf", cc_zf, e.zf);
                        checkb("cc_sf", cc_sf, e.sf);
                        checkb("cc_of", cc_of, e.of);
                    end
                end
                held   = out_valid && !out_ready;
                held_v = valE;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   lat;
        repeat (3) @(posedge clk);
        #1;
        checkb("rst_out_valid", out_valid, 1'b0);
        check("rst_valE", valE, '0);
        checkb("rst_cnd", cnd, 1'b0);
        checkb("rst_err", exe_err, 1'b0);
        checkb("rst_zf", cc_zf, 1'b1);
        checkb("rst_sf", cc_sf, 1'b0);
        checkb("rst_of", cc_of, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        checkb("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rdy_mode = 1;

        issue(4'h6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, '0, 1'b1);
        drain();
        checkb("add_of", cc_of, 1'b1);
        checkb("add_sf", cc_sf, 1'b1);
        checkb("add_zf", cc_zf, 1'b0);

        issue(4'h6, 4'd1, 64'd5, 64'd5, '0, 1'b1);
        issue(4'h7, 4'd1, '0, '0, 64'h40, 1'b0);
        issue(4'h7, 4'd6, '0, '0, 64'h40, 1'b0);
        drain();
        checkb("sub_zf", cc_zf, 1'b1);
        issue(4'h6, 4'd0, 64'd1, 64'd1, '0, 1'b1);
        issue(4'h6, 4'd1, 64'd5, 64'd5, '0, 1'b0);
        issue(4'h7, 4'd3, '0, '0, '0, 1'b0);
        drain();
        checkb("squash_zf", cc_zf, 1'b0);

        issue(4'h6, 4'd7, 64'd3, 64'd3, '0, 1'b1);
        issue(4'h7, 4'd9, '0, '0, '0, 1'b0);
        issue(4'h2, 4'd8, 64'h77, '0, '0, 1'b0);
        drain();
        checkb("bad_zf", cc_zf, 1'b0);

        rdy_mode = 2;
        issue(4'hA, 4'd0, '0, 64'h100, '0, 1'b0);
        icode = 4'h3; ifun = 4'd0; valC = 64'hDEAD; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkb("stall_out_valid", out_valid, 1'b1);
            check("stall_valE", valE, 64'hF8);
            checkb("stall_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        drain();

        for (int i = 0; i < 400; i++) begin
            logic [3:0] ic, fn;
            word_t      a, b, c;
            ic = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) ic = 4'h6;
            else if ($urandom_range(0, 3) == 0) ic = 4'h7;
            fn = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c = {$urandom, $urandom};
            case ($urandom_range(0, 6))
                0: b = a;
                1: a = 64'h8000_0000_0000_0000;
                2: b = 64'h7FFF_FFFF_FFFF_FFFF;
                3: a = 64'(a[7:0]);
                default: ;
            endcase
            issue(ic, fn, a, b, c, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 1;
        drain();

`ifdef Y86_MUL_EN
        issue(4'h6, 4'd4, 64'd7, -64'sd3, '0, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 200);
        check("mul_latency", word_t'(lat), word_t'(DATA_W + 1));
        check("mul_valE", valE, -64'sd21);
        drain();
        checkb("mul_sf", cc_sf, 1'b1);
        checkb("mul_of", cc_of, 1'b0);

        issue(4'h6, 4'd4, 64'd9, 64'd11, '0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        sb.delete();
        model_reset();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            seen |= out_valid;
        end
        checkb("mul_reset_no_output", seen, 1'b0);
        @(posedge clk);
        #1;
`endif

        issue(4'h6, 4'd1, 64'd1, 64'd0, '0, 1'b1);
        drain();
        rdy_mode = 2;
        issue(4'h3, 4'd0, '0, '0, 64'h55, 1'b0);
        rst_n = 1'b0;
        #2;
        sb.delete();
        model_reset();
        checkb("midrst_out_valid", out_valid, 1'b0);
        check("midrst_valE", valE, '0);
        checkb("midrst_zf", cc_zf, 1'b1);
        checkb("midrst_sf", cc_sf, 1'b0);
        checkb("midrst_of", cc_of, 1'b0);
        rdy_mode = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkb("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        issue(4'h9, 4'd0, '0, 64'h200, '0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
